// File: rtl/perm_seq_ctrl.sv
// perm_seq_ctrl: steps the permutation generator and cost accumulator through ITER_TOTAL
// iterations with prune, accumulate timeout and result back-pressure.
module perm_seq_ctrl #(
    parameter int ITER_TOTAL  = 40320,
    parameter int CNT_W       = 16,
    parameter int ACC_TIMEOUT = 0,
    parameter int TO_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             permute_valid,
    input  logic             sum_valid,
    input  logic             prune,
    input  logic             result_ready,
    output logic             permute_out,
    output logic             sum_start,
    output logic             sum_out,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] iter_count,
    output logic             timeout_err
);
    typedef enum logic [2:0] {IDLE, PERMUTE, ACCUMULATE, RESULT, DONE} state_t;
    state_t state, state_nx;
    logic [TO_W-1:0] to_cnt;
    logic last, timed_out, advance, go, to_hit;
    assign last      = iter_count == CNT_W'(ITER_TOTAL - 1);
    assign timed_out = (ACC_TIMEOUT != 0) && (to_cnt == TO_W'(ACC_TIMEOUT - 1));
    assign permute_out = state == PERMUTE;
    assign sum_out     = state == RESULT;
    assign busy        = state == PERMUTE || state == ACCUMULATE || state == RESULT;
    assign done        = state == DONE;
    always_comb begin
        state_nx = state;
        advance  = 1'b0;
        go       = 1'b0;
        to_hit   = 1'b0;
        case (state)
            IDLE, DONE: begin
                go       = start;
                state_nx = start ? PERMUTE : state;
            end
            PERMUTE: state_nx = permute_valid ? ACCUMULATE : PERMUTE;
            // sum_valid/prune are only meaningful once the sum_start pulse has gone out
            ACCUMULATE: begin
                if (!sum_start && sum_valid) state_nx = RESULT;
                else if (!sum_start && prune) advance = 1'b1;
                else if (timed_out) begin
                    advance = 1'b1;
                    to_hit  = 1'b1;
                end
            end
            RESULT: advance = result_ready;
            default: state_nx = IDLE;
        endcase
        if (advance) state_nx = last ? DONE : PERMUTE;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_start   <= 1'b0;
            out_valid   <= 1'b0;
            iter_count  <= '0;
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            sum_start <= state == PERMUTE && permute_valid;
            out_valid <= advance && last;
            to_cnt    <= state == ACCUMULATE ? to_cnt + TO_W'(1) : '0;
            if (go) iter_count <= '0;
            else if (advance && !last) iter_count <= iter_count + CNT_W'(1);
            if (go) timeout_err <= 1'b0;
            else if (to_hit) timeout_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_perm_seq_ctrl.sv
// tb_perm_seq_ctrl: table-driven iteration plans plus reset and stall sequences,
// with a queue of expected iteration indices checked at each sum_start pulse.
module tb_perm_seq_ctrl;
    localparam int IT = 6, CW = 4, AT = 8, TW = 8;
    localparam int NORM = 0, PRUNE = 1, BOTH = 2, TMO = 3, STALL = 4;
    logic clk = 0, rst = 0, start = 0, permute_valid = 0, sum_valid = 0, prune = 0, result_ready = 1;
    logic permute_out, sum_start, sum_out, out_valid, busy, done, timeout_err;
    logic [CW-1:0] iter_count;
    int errors = 0, checks = 0, n_ss = 0, n_ov = 0, ss0 = 0, ov0 = 0;
    int exp_q[$];
    typedef struct {
        int mode;
        logic exp_te;
    } vec_t;
    vec_t vecs[3][IT];

    perm_seq_ctrl #(.ITER_TOTAL(IT), .CNT_W(CW), .ACC_TIMEOUT(AT), .TO_W(TW)) dut (
        .clk(clk), .rst(rst), .start(start), .permute_valid(permute_valid),
        .sum_valid(sum_valid), .prune(prune), .result_ready(result_ready),
        .permute_out(permute_out), .sum_start(sum_start), .sum_out(sum_out),
        .out_valid(out_valid), .busy(busy), .done(done), .iter_count(iter_count),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (sum_start === 1'b1) n_ss++;
        if (out_valid === 1'b1) n_ov++;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic start_run();
        ov0 = n_ov;
        ss0 = n_ss;
        start = 1;
        tick();
        start = 0;
        chk("busy_after_start", busy, 1);
        chk("timeout_err_cleared", timeout_err, 0);
    endtask

    task automatic end_run(input logic exp_te);
        chk("done", done, 1);
        chk("out_valid_first_done", out_valid, 1);
        chk("busy_in_done", busy, 0);
        chk("iter_final", iter_count, IT - 1);
        chk("timeout_err_in_done", timeout_err, exp_te);
        tick();
        chk("out_valid_one_cycle", out_valid, 0);
        chk("done_hold", done, 1);
        chk("out_valid_count", n_ov - ov0, 1);
        chk("sum_start_count", n_ss - ss0, IT);
        chk("scoreboard_empty", exp_q.size(), 0);
    endtask

    task automatic do_iter(input int mode, input int exp_iter);
        int n;
        n = 0;
        while (permute_out !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        chk("permute_out", permute_out, 1);
        chk("iter_at_permute", iter_count, exp_iter);
        tick();
        permute_valid = 1;
        exp_q.push_back(exp_iter);
        tick();
        permute_valid = 0;
        chk("sum_start", sum_start, 1);
        chk("sb_iter", iter_count, exp_q.size() > 0 ? exp_q.pop_front() : -1);
        if (mode == STALL) result_ready = 0;
        tick();
        chk("sum_start_pulse", sum_start, 0);
        if (mode == PRUNE) begin
            prune = 1;
            tick();
            prune = 0;
            chk("prune_no_sum_out", sum_out, 0);
        end else if (mode == BOTH) begin
            sum_valid = 1;
            prune = 1;
            tick();
            sum_valid = 0;
            prune = 0;
            chk("both_sum_out", sum_out, 1);
            tick();
        end else if (mode == TMO) begin
            n = 1;
            while (busy && !permute_out && !sum_out && n < 20) begin
                tick();
                n++;
            end
            chk("acc_timeout_cycles", n, AT);
            chk("timeout_err_set", timeout_err, 1);
        end else begin
            tick();
            tick();
            sum_valid = 1;
            tick();
            sum_valid = 0;
            chk("sum_out", sum_out, 1);
            if (mode == STALL) begin
                for (int k = 0; k < 5; k++) begin
                    chk("stall_sum_out", sum_out, 1);
                    chk("stall_iter", iter_count, exp_iter);
                    chk("stall_busy", busy, 1);
                    start = (k == 2);
                    tick();
                end
                start = 0;
                chk("stall_sum_out_end", sum_out, 1);
                result_ready = 1;
            end
            tick();
        end
        chk("sum_out_clear", sum_out, 0);
        chk("iter_after", iter_count, exp_iter == IT - 1 ? exp_iter : exp_iter + 1);
    endtask

    initial begin
        for (int i = 0; i < IT; i++) begin
            vecs[0][i] = '{NORM, 1'b0};
            vecs[1][i] = '{(i == 2) ? PRUNE : (i == 3) ? BOTH : NORM, 1'b0};
            vecs[2][i] = '{(i == 0) ? TMO : (i == 1) ? STALL : NORM, 1'b1};
        end
        tick();
        tick();
        chk("reset_outs", {permute_out, sum_start, sum_out, out_valid, busy, done, timeout_err}, 0);
        chk("reset_iter", iter_count, 0);
        rst = 1;
        tick();
        chk("idle_no_busy", busy, 0);
        for (int r = 0; r < 3; r++) begin
            start_run();
            for (int i = 0; i < IT; i++) do_iter(vecs[r][i].mode, i);
            end_run(vecs[r][IT-1].exp_te);
        end
        // abort mid-accumulate of iteration 3 with an asynchronous reset
        start_run();
        for (int i = 0; i < 3; i++) do_iter(NORM, i);
        tick();
        permute_valid = 1;
        tick();
        permute_valid = 0;
        chk("pre_rst_sum_start", sum_start, 1);
        chk("pre_rst_iter", iter_count, 3);
        #2 rst = 0;
        #1;
        chk("async_rst_outs", {permute_out, sum_start, sum_out, out_valid, busy, done, timeout_err}, 0);
        chk("async_rst_iter", iter_count, 0);
        ov0 = n_ov;
        tick();
        tick();
        chk("rst_no_out_valid", n_ov - ov0, 0);
        rst = 1;
        tick();
        start_run();
        for (int i = 0; i < IT; i++) do_iter(NORM, i);
        end_run(1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
